// File: rtl/warp_pixel_reader.sv
// Consumer end of the perspective-transform stream: resolves each point to a texture or
// background pixel and prefetches pixels for the VGA sink. Optional macro WARP_BORDER_EN.
module warp_pixel_reader #(
  parameter int unsigned H_ACT     = 800,
  parameter int unsigned V_ACT     = 600,
  parameter int unsigned XFORM_LAT = 2,
  parameter int unsigned TEX_LAT   = 2,
  parameter int unsigned DEPTH     = 8,
  parameter logic [23:0] BG_RGB    = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_start,
  output logic        o_xform_start,
  output logic        o_xform_req,
  input  logic        i_xform_can_fetch,
  input  logic        i_xform_inside,
  input  logic [13:0] i_xform_point,
  output logic        o_tex_rd,
  output logic [13:0] o_tex_addr,
  input  logic [23:0] i_tex_data,
  input  logic        i_vga_req,
  output logic [23:0] o_vga_rgb,
  output logic        o_busy,
  output logic        o_underflow
);
  localparam int unsigned CNT_W  = 19;
  localparam int unsigned NPIX   = H_ACT * V_ACT;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned TSTG   = TEX_LAT + 1;
  localparam int unsigned OCC_W  = $clog2(DEPTH + XFORM_LAT + TSTG + 1) + 1;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;

  typedef enum logic [1:0] {IDLE, START, PRIME, STREAM} state_t;
  typedef enum logic [1:0] {SEL_BG, SEL_TEX, SEL_WHITE} sel_t;

  state_t             state, state_n;
  logic [XFORM_LAT:1] xv;
  logic [TSTG:1]      tv;
  sel_t               tsel [1:TSTG];
  logic [23:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]   issued, out_cnt;
  logic               req_c, wr_c, pop_c, vga_act_c, flush_c, clr_c, border_c;
  logic [OCC_W-1:0]   inflight_c;
  logic [6:0]         px_c, py_c;
  logic [23:0]        wdata_c;

  // Next state, credit check and FIFO write/pop decisions
  always_comb begin
    state_n    = state;
    req_c      = 1'b0;
    flush_c    = 1'b0;
    vga_act_c  = 1'b0;
    inflight_c = OCC_W'(o_xform_req);
    for (int i = 1; i <= int'(XFORM_LAT); i++) inflight_c = inflight_c + OCC_W'(xv[i]);
    for (int i = 1; i <= int'(TSTG); i++) inflight_c = inflight_c + OCC_W'(tv[i]);
    case (state)
      IDLE:  if (i_frame_start) state_n = START;
      START: begin
        flush_c = 1'b1;
        state_n = PRIME;
      end
      PRIME: begin
        if (i_frame_start) state_n = START;
        else if (i_xform_can_fetch) state_n = STREAM;
      end
      STREAM: begin
        if (i_frame_start) begin
          state_n = START;
        end else begin
          vga_act_c = i_vga_req;
          if (i_vga_req && out_cnt == CNT_W'(NPIX - 1)) state_n = IDLE;
          req_c = (state_n == STREAM) && (issued < CNT_W'(NPIX)) &&
                  ((OCC_W'(fifo_count) + inflight_c) < OCC_W'(DEPTH));
        end
      end
      default: state_n = IDLE;
    endcase
    // Any departure from STREAM (abort or frame end) discards tokens in flight
    clr_c = (state != STREAM) || i_frame_start;
    pop_c = vga_act_c && (fifo_count != '0);
    wr_c  = tv[TSTG] && !clr_c;
    px_c  = i_xform_point[13:7];
    py_c  = i_xform_point[6:0];
`ifdef WARP_BORDER_EN
    border_c = (px_c == 7'd0) || (px_c == 7'd127) || (py_c == 7'd0) || (py_c == 7'd127);
`else
    border_c = 1'b0;
`endif
    case (tsel[TSTG])
      SEL_TEX:   wdata_c = i_tex_data;
      SEL_WHITE: wdata_c = WHITE;
      default:   wdata_c = BG_RGB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_xform_start <= 1'b0;
      o_xform_req   <= 1'b0;
      o_tex_rd      <= 1'b0;
      o_tex_addr    <= '0;
      o_vga_rgb     <= '0;
      o_busy        <= 1'b0;
      o_underflow   <= 1'b0;
      xv            <= '0;
      tv            <= '0;
      for (int k = 1; k <= int'(TSTG); k++) tsel[k] <= SEL_BG;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      issued        <= '0;
      out_cnt       <= '0;
    end else begin
      state         <= state_n;
      o_xform_start <= (state_n == START);
      o_busy        <= (state_n != IDLE);
      o_xform_req   <= req_c;
      o_tex_rd      <= 1'b0;
      if (clr_c) begin
        xv <= '0;
        tv <= '0;
      end else begin
        xv[1] <= o_xform_req;
        for (int k = 2; k <= int'(XFORM_LAT); k++) xv[k] <= xv[k-1];
        tv[1] <= xv[XFORM_LAT];
        for (int k = 2; k <= int'(TSTG); k++) tv[k] <= tv[k-1];
      end
      tsel[1] <= !i_xform_inside ? SEL_BG : (border_c ? SEL_WHITE : SEL_TEX);
      for (int k = 2; k <= int'(TSTG); k++) tsel[k] <= tsel[k-1];
      if (xv[XFORM_LAT] && !clr_c && i_xform_inside && !border_c) begin
        o_tex_rd   <= 1'b1;
        o_tex_addr <= {py_c, px_c};
      end
      if (flush_c) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        issued     <= '0;
        out_cnt    <= '0;
      end else begin
        if (wr_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
        fifo_count <= fifo_count + FCNT_W'(wr_c) - FCNT_W'(pop_c);
        if (req_c) issued <= issued + CNT_W'(1);
        if (vga_act_c) out_cnt <= out_cnt + CNT_W'(1);
      end
      // Empty-FIFO requests still advance the raster with the background colour
      if (vga_act_c) begin
        if (pop_c) begin
          o_vga_rgb <= mem[rd_ptr];
        end else begin
          o_vga_rgb   <= BG_RGB;
          o_underflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_c) mem[wr_ptr] <= wdata_c;
  end

endmodule
